// File: rtl/instruction_decode_pkg.sv
// ---------------------------------------------------------------------------
// instruction_decode_pkg
//   Shared definitions for the RV32I ID stage: opcode encodings, ALU-op
//   encodings, the canonical NOP instruction, the EX control bundle and the
//   opcode -> control decode helpers.
// ---------------------------------------------------------------------------
package instruction_decode_pkg;

    localparam int XLEN_DEFAULT     = 32;
    localparam int REG_ADDR_DEFAULT = 5;

    localparam logic [6:0] OPCODE_R      = 7'b0110011;
    localparam logic [6:0] OPCODE_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // addi x0,x0,0 -- what a bubble looks like architecturally
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       memToReg;
        logic       aluSrc;
        logic       branch;
        logic [1:0] aluOp;
    } controlBundle_t;

    localparam controlBundle_t CTRL_NOP = '0;

    function automatic controlBundle_t decodeControl(input logic [6:0] opcode);
        controlBundle_t c;
        c = CTRL_NOP;
        case (opcode)
            OPCODE_R:      c = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALUOP_FUNCT};
            OPCODE_I_ALU:  c = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALUOP_FUNCT};
            OPCODE_LOAD:   c = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, ALUOP_ADD};
            OPCODE_STORE:  c = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, ALUOP_ADD};
            OPCODE_BRANCH: c = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALUOP_SUB};
            default:       c = CTRL_NOP;
        endcase
        return c;
    endfunction

    // Opcodes this stage understands; anything else is a NOP that never stalls.
    function automatic logic isKnownOpcode(input logic [6:0] opcode);
        return (opcode == OPCODE_R) || (opcode == OPCODE_I_ALU) ||
               (opcode == OPCODE_LOAD) || (opcode == OPCODE_STORE) ||
               (opcode == OPCODE_BRANCH);
    endfunction

    // Only these formats actually read rs2; for I-type the rs2 field is immediate bits.
    function automatic logic usesRs2(input logic [6:0] opcode);
        return (opcode == OPCODE_R) || (opcode == OPCODE_STORE) ||
               (opcode == OPCODE_BRANCH);
    endfunction

endpackage

// File: rtl/instruction_decode_register_file.sv
// ---------------------------------------------------------------------------
// instruction_decode_register_file
//   32 x XLEN integer register file: two combinational read ports, one write
//   port. x0 is hardwired to zero. A read of the register being written this
//   cycle returns the write data (write-through), so WB -> ID needs no bypass.
//   Ports:
//     clock, reset          clock / synchronous active-high reset (clears all)
//     rs1Addr, rs2Addr      read addresses
//     rs1Data, rs2Data      read data
//     writeEnable, writeAddr, writeData   writeback port
// ---------------------------------------------------------------------------
module instruction_decode_register_file #(
    parameter int XLEN     = 32,
    parameter int REG_ADDR = 5
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [REG_ADDR-1:0] rs1Addr,
    input  logic [REG_ADDR-1:0] rs2Addr,
    output logic [XLEN-1:0]     rs1Data,
    output logic [XLEN-1:0]     rs2Data,
    input  logic                writeEnable,
    input  logic [REG_ADDR-1:0] writeAddr,
    input  logic [XLEN-1:0]     writeData
);
    localparam int NUM_REGS = 1 << REG_ADDR;

    logic [XLEN-1:0] regs [NUM_REGS];
    logic            writeValid;

    assign writeValid = writeEnable && (writeAddr != '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (writeValid) begin
            regs[writeAddr] <= writeData;
        end
    end

    always_comb begin
        rs1Data = regs[rs1Addr];
        if (rs1Addr == '0) begin
            rs1Data = '0;
        end else if (writeValid && (writeAddr == rs1Addr)) begin
            rs1Data = writeData;
        end
    end

    always_comb begin
        rs2Data = regs[rs2Addr];
        if (rs2Addr == '0) begin
            rs2Data = '0;
        end else if (writeValid && (writeAddr == rs2Addr)) begin
            rs2Data = writeData;
        end
    end

endmodule

// File: rtl/instruction_decode.sv
// ---------------------------------------------------------------------------
// instruction_decode
//   ID stage of a 5-stage RV32I pipeline. Decodes the IF/ID instruction,
//   reads the register file, builds the sign-extended immediate, detects
//   load-use hazards and holds the ID/EX pipeline register.
//   Ports:
//     clock, reset                  clock / synchronous active-high reset
//     ifIdInstruction, ifIdIn       instruction and PC+4 from IF/ID
//     exMemPc                       branch taken in MEM -> flush ID/EX
//     memWbRegWrite/Rd/Data         writeback port into the register file
//     stall                         combinational request to hold PC and IF/ID
//     idEx*                         registered ID/EX fields and control bundle
// ---------------------------------------------------------------------------
module instruction_decode
    import instruction_decode_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int REG_ADDR = REG_ADDR_DEFAULT
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [XLEN-1:0]     ifIdInstruction,
    input  logic [XLEN-1:0]     ifIdIn,
    input  logic                exMemPc,
    input  logic                memWbRegWrite,
    input  logic [REG_ADDR-1:0] memWbRd,
    input  logic [XLEN-1:0]     memWbData,
    output logic                stall,
    output logic [XLEN-1:0]     idExNpc,
    output logic [XLEN-1:0]     idExRs1Data,
    output logic [XLEN-1:0]     idExRs2Data,
    output logic [XLEN-1:0]     idExImm,
    output logic [REG_ADDR-1:0] idExRs1,
    output logic [REG_ADDR-1:0] idExRs2,
    output logic [REG_ADDR-1:0] idExRd,
    output logic [2:0]          idExFunct3,
    output logic                idExFunct7b5,
    output logic [1:0]          idExAluOp,
    output logic                idExRegWrite,
    output logic                idExMemRead,
    output logic                idExMemWrite,
    output logic                idExMemToReg,
    output logic                idExAluSrc,
    output logic                idExBranch
);
    logic [6:0]          opcode;
    logic [REG_ADDR-1:0] rs1;
    logic [REG_ADDR-1:0] rs2;
    logic [REG_ADDR-1:0] rd;
    logic [XLEN-1:0]     rs1Data;
    logic [XLEN-1:0]     rs2Data;
    logic [XLEN-1:0]     immNext;
    controlBundle_t      ctrlNext;
    logic                hazard;
    logic                bubble;

    assign opcode   = ifIdInstruction[6:0];
    assign rd       = ifIdInstruction[11:7];
    assign rs1      = ifIdInstruction[19:15];
    assign rs2      = ifIdInstruction[24:20];
    assign ctrlNext = decodeControl(opcode);

    instruction_decode_register_file #(
        .XLEN     (XLEN),
        .REG_ADDR (REG_ADDR)
    ) u_regFile (
        .clock       (clock),
        .reset       (reset),
        .rs1Addr     (rs1),
        .rs2Addr     (rs2),
        .rs1Data     (rs1Data),
        .rs2Data     (rs2Data),
        .writeEnable (memWbRegWrite),
        .writeAddr   (memWbRd),
        .writeData   (memWbData)
    );

    // Immediate generator; R-type and unknown opcodes carry no immediate.
    always_comb begin
        immNext = '0;
        case (opcode)
            OPCODE_I_ALU, OPCODE_LOAD:
                immNext = {{20{ifIdInstruction[31]}}, ifIdInstruction[31:20]};
            OPCODE_STORE:
                immNext = {{20{ifIdInstruction[31]}}, ifIdInstruction[31:25],
                           ifIdInstruction[11:7]};
            OPCODE_BRANCH:
                immNext = {{19{ifIdInstruction[31]}}, ifIdInstruction[31],
                           ifIdInstruction[7], ifIdInstruction[30:25],
                           ifIdInstruction[11:8], 1'b0};
            default:
                immNext = '0;
        endcase
    end

    // Load-use: the load in EX cannot forward to this instruction in time.
    // Every known opcode reads rs1; unknown opcodes never stall.
    assign hazard = idExMemRead && (idExRd != '0) && isKnownOpcode(opcode) &&
                    ((idExRd == rs1) || ((idExRd == rs2) && usesRs2(opcode)));

    // A taken branch kills this instruction anyway, so the stall is moot.
    assign stall  = hazard && !exMemPc;
    assign bubble = hazard || exMemPc;

    always_ff @(posedge clock) begin
        if (reset || bubble) begin
            idExNpc      <= '0;
            idExRs1Data  <= '0;
            idExRs2Data  <= '0;
            idExImm      <= '0;
            idExRs1      <= '0;
            idExRs2      <= '0;
            idExRd       <= '0;
            idExFunct3   <= '0;
            idExFunct7b5 <= 1'b0;
            idExAluOp    <= '0;
            idExRegWrite <= 1'b0;
            idExMemRead  <= 1'b0;
            idExMemWrite <= 1'b0;
            idExMemToReg <= 1'b0;
            idExAluSrc   <= 1'b0;
            idExBranch   <= 1'b0;
        end else begin
            idExNpc      <= ifIdIn;
            idExRs1Data  <= rs1Data;
            idExRs2Data  <= rs2Data;
            idExImm      <= immNext;
            idExRs1      <= rs1;
            idExRs2      <= rs2;
            idExRd       <= rd;
            idExFunct3   <= ifIdInstruction[14:12];
            idExFunct7b5 <= ifIdInstruction[30];
            idExAluOp    <= ctrlNext.aluOp;
            idExRegWrite <= ctrlNext.regWrite;
            idExMemRead  <= ctrlNext.memRead;
            idExMemWrite <= ctrlNext.memWrite;
            idExMemToReg <= ctrlNext.memToReg;
            idExAluSrc   <= ctrlNext.aluSrc;
            idExBranch   <= ctrlNext.branch;
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// ---------------------------------------------------------------------------
// tb_instruction_decode
//   Directed-vector bench for the ID stage. Expected values are hand-encoded
//   RV32I instructions and their hand-decoded fields.
// ---------------------------------------------------------------------------
module tb_instruction_decode;
    logic        clock;
    logic        reset;
    logic [31:0] ifIdInstruction;
    logic [31:0] ifIdIn;
    logic        exMemPc;
    logic        memWbRegWrite;
    logic [4:0]  memWbRd;
    logic [31:0] memWbData;
    logic        stall;
    logic [31:0] idExNpc;
    logic [31:0] idExRs1Data;
    logic [31:0] idExRs2Data;
    logic [31:0] idExImm;
    logic [4:0]  idExRs1;
    logic [4:0]  idExRs2;
    logic [4:0]  idExRd;
    logic [2:0]  idExFunct3;
    logic        idExFunct7b5;
    logic [1:0]  idExAluOp;
    logic        idExRegWrite;
    logic        idExMemRead;
    logic        idExMemWrite;
    logic        idExMemToReg;
    logic        idExAluSrc;
    logic        idExBranch;

    int errorCount = 0;
    int checkCount = 0;

    // Hand-encoded instructions
    localparam logic [31:0] I_NOP      = 32'h0000_0013; // addi x0,x0,0
    localparam logic [31:0] I_ADDI_651 = 32'h0012_8313; // addi x6,x5,1
    localparam logic [31:0] I_ADDI_870 = 32'h0003_8413; // addi x8,x7,0
    localparam logic [31:0] I_ADDI_100 = 32'h0000_0093; // addi x1,x0,0
    localparam logic [31:0] I_LW_21    = 32'h0000_A103; // lw x2,0(x1)
    localparam logic [31:0] I_LW_01    = 32'h0000_A003; // lw x0,0(x1)
    localparam logic [31:0] I_LW_311   = 32'h0000_AF83; // lw x31,0(x1)
    localparam logic [31:0] I_ADD_324  = 32'h0041_01B3; // add x3,x2,x4
    localparam logic [31:0] I_ADD_342  = 32'h0022_01B3; // add x3,x4,x2
    localparam logic [31:0] I_ADD_304  = 32'h0040_01B3; // add x3,x0,x4
    localparam logic [31:0] I_ADDI_342 = 32'h0022_0193; // addi x3,x4,2
    localparam logic [31:0] I_SW       = 32'hFE51_2E23; // sw x5,-4(x2)
    localparam logic [31:0] I_BEQ      = 32'hFE00_0CE3; // beq x0,x0,-8
    localparam logic [31:0] I_ILLEGAL  = 32'hFFFF_FFFF;

    instruction_decode dut (
        .clock           (clock),
        .reset           (reset),
        .ifIdInstruction (ifIdInstruction),
        .ifIdIn          (ifIdIn),
        .exMemPc         (exMemPc),
        .memWbRegWrite   (memWbRegWrite),
        .memWbRd         (memWbRd),
        .memWbData       (memWbData),
        .stall           (stall),
        .idExNpc         (idExNpc),
        .idExRs1Data     (idExRs1Data),
        .idExRs2Data     (idExRs2Data),
        .idExImm         (idExImm),
        .idExRs1         (idExRs1),
        .idExRs2         (idExRs2),
        .idExRd          (idExRd),
        .idExFunct3      (idExFunct3),
        .idExFunct7b5    (idExFunct7b5),
        .idExAluOp       (idExAluOp),
        .idExRegWrite    (idExRegWrite),
        .idExMemRead     (idExMemRead),
        .idExMemWrite    (idExMemWrite),
        .idExMemToReg    (idExMemToReg),
        .idExAluSrc      (idExAluSrc),
        .idExBranch      (idExBranch)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkValue(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("FAIL %s: got %h expected %h", tag, observed, expected);
        end else begin
            $display("ok   %s: %h", tag, observed);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // All eight control bits packed {regWrite,memRead,memWrite,memToReg,aluSrc,branch,aluOp}
    function automatic logic [31:0] ctrlWord();
        return {24'd0, idExRegWrite, idExMemRead, idExMemWrite, idExMemToReg,
                idExAluSrc, idExBranch, idExAluOp};
    endfunction

    task automatic checkBubble(input string tag);
        checkValue({tag, " ctrl"}, ctrlWord(), 32'h0);
        checkValue({tag, " npc"}, idExNpc, 32'h0);
        checkValue({tag, " rd"}, {27'd0, idExRd}, 32'h0);
    endtask

    initial begin
        logic [31:0] instr;

        reset           = 1'b1;
        ifIdInstruction = I_NOP;
        ifIdIn          = 32'h0000_0004;
        exMemPc         = 1'b0;
        memWbRegWrite   = 1'b0;
        memWbRd         = 5'd0;
        memWbData       = 32'h0;

        // 1 Reset
        tick();
        tick();
        checkBubble("reset");
        checkValue("reset rs1Data", idExRs1Data, 32'h0);
        checkValue("reset imm", idExImm, 32'h0);
        checkValue("reset stall", {31'd0, stall}, 32'h0);
        reset = 1'b0;
        for (int i = 1; i < 32; i++) begin
            instr = {7'd0, 5'(i), 5'(i), 3'd0, 5'd0, 7'b0110011};
            ifIdInstruction = instr;
            tick();
            checkValue($sformatf("reset read x%0d", i), idExRs1Data | idExRs2Data, 32'h0);
        end

        // 2 Writeback then read
        ifIdInstruction = I_NOP;
        memWbRegWrite = 1'b1; memWbRd = 5'd5; memWbData = 32'hDEAD_BEEF;
        tick();
        memWbRegWrite = 1'b0;
        ifIdInstruction = I_ADDI_651; ifIdIn = 32'h0000_0010;
        tick();
        checkValue("addi rs1Data", idExRs1Data, 32'hDEAD_BEEF);
        checkValue("addi imm", idExImm, 32'h1);
        checkValue("addi ctrl", ctrlWord(), 32'h8A);  // regWrite, aluSrc, aluOp=10
        checkValue("addi rd", {27'd0, idExRd}, 32'd6);
        checkValue("addi npc", idExNpc, 32'h0000_0010);

        memWbRegWrite = 1'b1; memWbRd = 5'd7; memWbData = 32'hCAFE_F00D;
        ifIdInstruction = I_ADDI_870;
        tick();
        checkValue("writethru rs1Data", idExRs1Data, 32'hCAFE_F00D);
        memWbRegWrite = 1'b0;
        tick();
        checkValue("stored x7", idExRs1Data, 32'hCAFE_F00D);

        memWbRegWrite = 1'b1; memWbRd = 5'd0; memWbData = 32'h0000_1234;
        ifIdInstruction = I_ADDI_100;
        tick();
        checkValue("x0 writethru", idExRs1Data, 32'h0);
        memWbRegWrite = 1'b0;
        tick();
        checkValue("x0 after write", idExRs1Data, 32'h0);

        // 3 Load-use on rs1
        ifIdInstruction = I_LW_21;
        tick();
        checkValue("lw ctrl", ctrlWord(), 32'hD8);  // regWrite, memRead, memToReg, aluSrc
        ifIdInstruction = I_ADD_324; ifIdIn = 32'h0000_0020;
        #1;
        checkValue("loaduse stall", {31'd0, stall}, 32'h1);
        tick();
        checkBubble("loaduse bubble");
        checkValue("after bubble stall", {31'd0, stall}, 32'h0);
        tick();
        checkValue("add ctrl", ctrlWord(), 32'h82);
        checkValue("add rd", {27'd0, idExRd}, 32'd3);

        // Load-use on rs2
        ifIdInstruction = I_LW_21;
        tick();
        ifIdInstruction = I_ADD_342;
        #1;
        checkValue("loaduse rs2 stall", {31'd0, stall}, 32'h1);
        tick();
        // I-type: rs2 field is immediate bits, must not stall
        ifIdInstruction = I_LW_21;
        tick();
        ifIdInstruction = I_ADDI_342;
        #1;
        checkValue("itype no stall", {31'd0, stall}, 32'h0);
        tick();
        checkValue("itype imm", idExImm, 32'h2);
        // Load to x0 never creates a hazard
        ifIdInstruction = I_LW_01;
        tick();
        ifIdInstruction = I_ADD_304;
        #1;
        checkValue("lw x0 no stall", {31'd0, stall}, 32'h0);
        tick();

        // 4 Flush priority
        ifIdInstruction = I_LW_21;
        tick();
        ifIdInstruction = I_ADD_324; exMemPc = 1'b1;
        #1;
        checkValue("flush stall", {31'd0, stall}, 32'h0);
        tick();
        checkBubble("flush+loaduse");
        ifIdInstruction = I_ADD_304;
        tick();
        checkBubble("flush add");
        exMemPc = 1'b0;

        // 5 Immediates
        ifIdInstruction = I_SW;
        tick();
        checkValue("sw imm", idExImm, 32'hFFFF_FFFC);
        checkValue("sw ctrl", ctrlWord(), 32'h28);  // memWrite, aluSrc
        ifIdInstruction = I_BEQ;
        tick();
        checkValue("beq imm", idExImm, 32'hFFFF_FFF8);
        checkValue("beq ctrl", ctrlWord(), 32'h05); // branch, aluOp=01

        // 6 Illegal opcode right after a load to x31 (its rs1 field)
        ifIdInstruction = I_LW_311;
        tick();
        ifIdInstruction = I_ILLEGAL; ifIdIn = 32'h0000_0200;
        #1;
        checkValue("illegal stall", {31'd0, stall}, 32'h0);
        tick();
        checkValue("illegal ctrl", ctrlWord(), 32'h0);
        checkValue("illegal npc", idExNpc, 32'h0000_0200);

        // Reset asserted mid-stall
        ifIdInstruction = I_LW_21;
        tick();
        ifIdInstruction = I_ADD_324;
        #1;
        checkValue("prereset stall", {31'd0, stall}, 32'h1);
        reset = 1'b1;
        tick();
        checkBubble("reset midstall");
        checkValue("reset midstall stall", {31'd0, stall}, 32'h0);
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
